led_blink_scheduler: RTL and testbench

- Shares one physical LED between N_REQ requesters; each requester asks for a burst of K blinks.
- Round-robin, non-preemptive arbitration. A sequencing FSM generates timed ON/OFF phases on led_out.
- Sits between status/event sources and the board LED. Replaces a free-running blinker when several agents need to signal on the same LED.

---
 rtl/led_pkg.sv | 35 +++
 rtl/led_blink_scheduler_rr_pick.sv | 51 +++++
 rtl/led_blink_scheduler.sv | 167 ++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED blink scheduler:
//   - led_state_e   : sequencing FSM state encoding
//   - DEF_*_CYCLES  : default ON/OFF phase lengths
//   - clog2 / max2  : elaboration-time helpers for width derivation
// Optional build macro used by the importers: LED_BLINK_SCHED_FIXED_PRIO_EN
// ----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } led_state_e;

    localparam int unsigned DEF_ON_CYCLES  = 4;
    localparam int unsigned DEF_OFF_CYCLES = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : led_pkg

// File: rtl/led_blink_scheduler_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational requester selector for the LED blink scheduler.
// Default build: first set request bit searching upward from i_rr_ptr,
// wrapping modulo N_REQ.
// With LED_BLINK_SCHED_FIXED_PRIO_EN defined: lowest set request index wins
// and the pointer input does not exist.
// Ports:
//   i_req       request vector, bit i = requester i
//   i_rr_ptr    search start index (round-robin build only)
//   o_winner_c  winning index (0 when no request)
//   o_onehot_c  one-hot of the winner (0 when no request)
// ----------------------------------------------------------------------------
module rr_pick
    import led_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] i_rr_ptr,
`endif
    output logic [IDX_W-1:0] o_winner_c,
    output logic [N_REQ-1:0] o_onehot_c
);

    logic        w_found;
    int unsigned w_idx;

    // Scan candidates in priority order; the first hit is kept
    always_comb begin
        w_found    = 1'b0;
        w_idx      = 0;
        o_winner_c = '0;
        o_onehot_c = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
`ifdef LED_BLINK_SCHED_FIXED_PRIO_EN
            w_idx = off;
`else
            w_idx = (32'(i_rr_ptr) + off) % N_REQ;
`endif
            if (!w_found && (((i_req >> w_idx) & N_REQ'(1)) != '0)) begin
                w_found    = 1'b1;
                o_winner_c = IDX_W'(w_idx);
                o_onehot_c = N_REQ'(1) << w_idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/led_blink_scheduler.sv
// ----------------------------------------------------------------------------
// led_blink_scheduler
// Shares one LED between N_REQ requesters. Each granted requester gets a
// non-preemptive burst of K blinks (K sampled from blink_cnt at grant), each
// blink being ON_CYCLES high followed by OFF_CYCLES low, then a one-cycle
// DONE. Arbitration is round-robin, or fixed lowest-index priority when
// LED_BLINK_SCHED_FIXED_PRIO_EN is defined.
// Ports:
//   clk        system clock, rising edge
//   clear      asynchronous active-high reset
//   req        level request per requester
//   blink_cnt  per-requester blink count, [i*CNT_W +: CNT_W] = requester i
//   grant      one-hot, held for the whole burst (registered)
//   busy       FSM not in IDLE (registered)
//   done       one-cycle pulse in the last burst cycle (registered)
//   led_out    shared LED drive (registered)
// ----------------------------------------------------------------------------
module led_blink_scheduler
    import led_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] blink_cnt,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   done,
    output logic                   led_out
);

    localparam int unsigned IDX_W    = clog2(N_REQ);
    localparam int unsigned TMR_W    = clog2(max2(ON_CYCLES, OFF_CYCLES)) + 1;
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

    led_state_e         r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_rem;
    logic [N_REQ-1:0]   r_grant;
    logic               r_busy;
    logic               r_done;
    logic               r_led;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_winner;
`endif

    logic [IDX_W-1:0]   w_winner;
    logic [N_REQ-1:0]   w_onehot;
    logic [CNT_W-1:0]   w_cnt;

    rr_pick #(
        .N_REQ      (N_REQ)
    ) u_rr_pick (
        .i_req      (req),
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
        .i_rr_ptr   (r_rr_ptr),
`endif
        .o_winner_c (w_winner),
        .o_onehot_c (w_onehot)
    );

    // Blink count of the current winner
    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_cnt = blink_cnt[i*CNT_W +: CNT_W];
            end
        end
    end

    // Sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_rem    <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_led    <= 1'b0;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
            r_rr_ptr <= '0;
            r_winner <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req != '0) begin
                        r_grant  <= w_onehot;
                        r_busy   <= 1'b1;
                        r_rem    <= w_cnt;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
                        r_winner <= w_winner;
`endif
                        // A zero-length burst still produces its DONE cycle
                        if (w_cnt == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_led   <= 1'b0;
                        end else begin
                            r_state <= ST_ON;
                            r_led   <= 1'b1;
                            r_timer <= ON_LOAD;
                        end
                    end
                end
                ST_ON: begin
                    if (r_timer == '0) begin
                        r_state <= ST_OFF;
                        r_led   <= 1'b0;
                        r_timer <= OFF_LOAD;
                        if (r_rem != '0) begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_OFF: begin
                    if (r_timer == '0) begin
                        if (r_rem != '0) begin
                            r_state <= ST_ON;
                            r_led   <= 1'b1;
                            r_timer <= ON_LOAD;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_led   <= 1'b0;
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
                    // Next search starts just past the requester just served
                    if (r_winner == IDX_W'(N_REQ - 1)) begin
                        r_rr_ptr <= '0;
                    end else begin
                        r_rr_ptr <= r_winner + IDX_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign done    = r_done;
    assign led_out = r_led;

endmodule : led_blink_scheduler

// File: tb/tb_led_blink_scheduler.sv
// ----------------------------------------------------------------------------
// tb_led_blink_scheduler
// Directed bench for led_blink_scheduler (N_REQ=4, CNT_W=4, ON=OFF=4).
// A burst-level reference model (burst start time, blink count, winner)
// predicts every output on every cycle; directed scenarios add literal
// expectations for the burst shape, grant order and reset behaviour.
// Honours LED_BLINK_SCHED_FIXED_PRIO_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_led_blink_scheduler;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int ON  = 4;
    localparam int OFF = 4;
    localparam int P   = ON + OFF;

    logic            clk = 1'b0;
    logic            clear;
    logic [N-1:0]    req;
    logic [N*CW-1:0] blink_cnt;
    logic [N-1:0]    grant;
    logic            busy;
    logic            done;
    logic            led_out;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    led_blink_scheduler #(
        .N_REQ      (N),
        .CNT_W      (CW),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .req        (req),
        .blink_cnt  (blink_cnt),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is (winner, K, elapsed cycles since grant)
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_k      = 0;
    int m_w      = 0;
    int m_ptr    = 0;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        int idx;
        for (int off = 0; off < N; off++) begin
`ifdef LED_BLINK_SCHED_FIXED_PRIO_EN
            idx = off;
`else
            idx = (ptr + off) % N;
`endif
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge clear) begin : model_blk
        int w;
        if (clear) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_ptr    <= 0;
        end else if (!m_active) begin
            if (req != '0) begin
                w = pick(req, m_ptr);
                m_w      <= w;
                m_k      <= int'(blink_cnt[w*CW +: CW]);
                m_t      <= 0;
                m_active <= 1'b1;
            end
        end else if (m_t >= m_k * P) begin
            m_active <= 1'b0;
            m_ptr    <= (m_w + 1) % N;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_grant", 32'(grant), m_active ? (32'd1 << m_w) : 32'd0);
            check("model_busy", 32'(busy), 32'(m_active));
            check("model_done", 32'(done), 32'(m_active && (m_t == m_k * P)));
            check("model_led", 32'(led_out),
                  32'(m_active && (m_t < m_k * P) && ((m_t % P) < ON)));
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
    task automatic run_round_robin();
        logic [N-1:0] rr_exp [5];
        logic [N-1:0] seen [$];
        int           starts [$];
        logic [N-1:0] prev;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = '0;
        @(negedge clk);
        req       = 4'b1111;
        blink_cnt = {4{4'd1}};
        for (int cyc = 1; cyc <= 80 && seen.size() < 5; cyc++) begin
            @(negedge clk);
            if (grant != '0 && grant != prev) begin
                seen.push_back(grant);
                starts.push_back(cyc);
            end
            prev = grant;
        end
        req = '0;
        check("rr_num_grants", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size(); i++) begin
            check($sformatf("rr_grant_%0d", i), 32'(seen[i]), 32'(rr_exp[i]));
        end
        for (int i = 1; i < starts.size(); i++) begin
            check($sformatf("rr_spacing_%0d", i), 32'(starts[i] - starts[i-1]), 32'd10);
        end
        idle_cycles(12);
    endtask
`else
    task automatic run_fixed_prio();
        int served;
        served = 0;
        @(negedge clk);
        req       = 4'b1010;
        blink_cnt = {4{4'd1}};
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (grant != '0) begin
                served++;
                check("fp_grant", 32'(grant), 32'h2);
            end
        end
        req = '0;
        check("fp_served", 32'(served > 0), 32'd1);
        idle_cycles(12);
    endtask
`endif

    task automatic run_single_burst();
        logic [15:0] led_tr;
        logic [N-1:0] g1;
        logic d16, d17, g18, b18;
        led_tr = '0;
        g1 = '0; d16 = 1'b0; d17 = 1'b0; g18 = 1'b0; b18 = 1'b0;
        @(negedge clk);
        req       = 4'b0001;
        blink_cnt = 16'h0002;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (cyc <= 16) led_tr[16-cyc] = led_out;
            if (cyc == 1)  g1  = grant;
            if (cyc == 16) d16 = done;
            if (cyc == 17) d17 = done;
            if (cyc == 18) begin g18 = |grant; b18 = busy; end
            // Mid-burst input changes must not disturb the burst
            if (cyc == 1) req = '0;
            if (cyc == 3) blink_cnt = 16'h0005;
        end
        check("sb_grant_c1", 32'(g1), 32'h1);
        check("sb_led_pattern", 32'(led_tr), 32'hF0F0);
        check("sb_done_c16", 32'(d16), 32'd0);
        check("sb_done_c17", 32'(d17), 32'd1);
        check("sb_grant_c18", 32'(g18), 32'd0);
        check("sb_busy_c18", 32'(b18), 32'd0);
        idle_cycles(3);
    endtask

    task automatic run_zero_count();
        @(negedge clk);
        req       = 4'b0100;
        blink_cnt = 16'h0000;
        @(negedge clk);
        check("zc_grant", 32'(grant), 32'h4);
        check("zc_done", 32'(done), 32'd1);
        check("zc_busy", 32'(busy), 32'd1);
        check("zc_led", 32'(led_out), 32'd0);
        req = '0;
        @(negedge clk);
        check("zc_grant_after", 32'(grant), 32'h0);
        check("zc_done_after", 32'(done), 32'd0);
        check("zc_busy_after", 32'(busy), 32'd0);
        idle_cycles(3);
    endtask

    task automatic run_mid_reset();
        bit got;
        @(negedge clk);
        req       = 4'b0100;
        blink_cnt = 16'h0300;
        idle_cycles(2);
        check("mr_led_before", 32'(led_out), 32'd1);
        check("mr_grant_before", 32'(grant), 32'h4);
        #2 clear = 1'b1;
        #1;
        check("mr_led_async", 32'(led_out), 32'd0);
        check("mr_grant_async", 32'(grant), 32'h0);
        check("mr_busy_async", 32'(busy), 32'd0);
        req       = 4'b1111;
        blink_cnt = {4{4'd1}};
        @(negedge clk);
        #2 clear = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 6 && !got; cyc++) begin
            @(negedge clk);
            if (grant != '0) got = 1'b1;
        end
        check("mr_grant_seen", 32'(got), 32'd1);
        check("mr_first_grant", 32'(grant), 32'h1);
        req = '0;
        idle_cycles(12);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin : main
        clear     = 1'b1;
        req       = '0;
        blink_cnt = '0;
        #20 clear = 1'b0;
        cmp_en = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            check("rst_outputs", {28'd0, grant}, 32'd0);
            check("rst_flags", {29'd0, busy, done, led_out}, 32'd0);
        end
`ifndef LED_BLINK_SCHED_FIXED_PRIO_EN
        run_round_robin();
`else
        run_fixed_prio();
`endif
        run_single_burst();
        run_zero_count();
        run_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_led_blink_scheduler
